// File: rtl/ex_mem_stage.sv
// Execute stage of the pipelined MIPS datapath.
// Selects forwarded operands, runs the ALU and captures the result and the
// MEM/WB control bits in the EX/MEM pipeline register. The registered result
// also feeds back into the stage's own forwarding mux.
module ex_mem_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                inValid,
    input  logic [2:0]          aluOperation,
    input  logic [WIDTH-1:0]    readData1,
    input  logic [WIDTH-1:0]    readData2,
    input  logic [WIDTH-1:0]    immediate,
    input  logic                aluSrc,
    input  logic [1:0]          forwardA,
    input  logic [1:0]          forwardB,
    input  logic [WIDTH-1:0]    wbData,
    input  logic [REG_ADDR-1:0] writeRegIn,
    input  logic                regWriteIn,
    input  logic                memReadIn,
    input  logic                memWriteIn,
    input  logic                memToRegIn,
    output logic [WIDTH-1:0]    aluResultOut,
    output logic [WIDTH-1:0]    writeDataOut,
    output logic [REG_ADDR-1:0] writeRegOut,
    output logic                regWriteOut,
    output logic                memReadOut,
    output logic                memWriteOut,
    output logic                memToRegOut,
    output logic                zeroOut,
    output logic                validOut
);

    // ALU operation codes produced by the ALU controller
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // EX/MEM pipeline register
    logic [WIDTH-1:0]    r_alu_result;
    logic [WIDTH-1:0]    r_write_data;
    logic [REG_ADDR-1:0] r_write_reg;
    logic                r_reg_write;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_mem_to_reg;
    logic                r_zero;
    logic                r_valid;

    logic [WIDTH-1:0]    w_op_a;
    logic [WIDTH-1:0]    w_fwd_b;
    logic [WIDTH-1:0]    w_op_b;
    logic [WIDTH-1:0]    w_alu_result;
    logic                w_zero;
    logic                w_ctrl_en;

    // Forwarding mux: 10 takes the registered EX/MEM result, 01 the WB data,
    // both 00 and 11 fall back to the register-file value.
    function automatic logic [WIDTH-1:0] fwd_mux(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] reg_val,
        input logic [WIDTH-1:0] ex_val,
        input logic [WIDTH-1:0] wb_val
    );
        logic [WIDTH-1:0] res;
        case (sel)
            2'b10:   res = ex_val;
            2'b01:   res = wb_val;
            default: res = reg_val;
        endcase
        return res;
    endfunction

    // Operand selection through the forwarding muxes and the immediate mux
    always_comb begin
        w_op_a  = fwd_mux(forwardA, readData1, r_alu_result, wbData);
        w_fwd_b = fwd_mux(forwardB, readData2, r_alu_result, wbData);
        if (aluSrc) begin
            w_op_b = immediate;
        end else begin
            w_op_b = w_fwd_b;
        end
    end

    // ALU: wrapping add/sub, signed compare immune to overflow, reserved codes give 0
    always_comb begin
        w_alu_result = {WIDTH{1'b0}};
        case (aluOperation)
            ALU_AND: w_alu_result = w_op_a & w_op_b;
            ALU_OR:  w_alu_result = w_op_a | w_op_b;
            ALU_ADD: w_alu_result = w_op_a + w_op_b;
            ALU_SUB: w_alu_result = w_op_a - w_op_b;
            ALU_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            default: w_alu_result = {WIDTH{1'b0}};
        endcase
        w_zero    = (w_alu_result == {WIDTH{1'b0}});
        w_ctrl_en = inValid;
    end

    // EX/MEM register update with priority rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_alu_result <= {WIDTH{1'b0}};
            r_write_data <= {WIDTH{1'b0}};
            r_write_reg  <= {REG_ADDR{1'b0}};
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_zero       <= 1'b0;
            r_valid      <= 1'b0;
        end else if (stall) begin
            r_alu_result <= r_alu_result;
            r_write_data <= r_write_data;
            r_write_reg  <= r_write_reg;
            r_reg_write  <= r_reg_write;
            r_mem_read   <= r_mem_read;
            r_mem_write  <= r_mem_write;
            r_mem_to_reg <= r_mem_to_reg;
            r_zero       <= r_zero;
            r_valid      <= r_valid;
        end else begin
            // Data fields always load; control bits are gated by the valid slot
            r_alu_result <= w_alu_result;
            r_write_data <= w_fwd_b;
            r_write_reg  <= writeRegIn;
            r_reg_write  <= regWriteIn & w_ctrl_en;
            r_mem_read   <= memReadIn & w_ctrl_en;
            r_mem_write  <= memWriteIn & w_ctrl_en;
            r_mem_to_reg <= memToRegIn & w_ctrl_en;
            r_zero       <= w_zero;
            r_valid      <= w_ctrl_en;
        end
    end

    assign aluResultOut = r_alu_result;
    assign writeDataOut = r_write_data;
    assign writeRegOut  = r_write_reg;
    assign regWriteOut  = r_reg_write;
    assign memReadOut   = r_mem_read;
    assign memWriteOut  = r_mem_write;
    assign memToRegOut  = r_mem_to_reg;
    assign zeroOut      = r_zero;
    assign validOut     = r_valid;

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute stage of the pipelined MIPS datapath: it consumes the 3-bit ALU operation code produced by the ALU controller, selects forwarded operands, performs the ALU operation and captures the result plus the MEM/WB control bits in the EX/MEM pipeline register. It sits between the ID/EX register and the data-memory stage. Its registered result also feeds its own forwarding path.

## Interface
Parameters:
- WIDTH, 32, datapath width in bits.
- REG_ADDR, 5, register-file address width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold EX/MEM register contents.
- flush  input  1  load a bubble into EX/MEM.
- inValid  input  1  ID/EX slot holds a real instruction.
- aluOperation  input  3  000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT; other codes are reserved.
- readData1, readData2  input  WIDTH  register operands from ID/EX.
- immediate  input  WIDTH  sign-extended immediate.
- aluSrc  input  1  1 selects `immediate` as ALU operand B.
- forwardA, forwardB  input  2  00 register value, 10 EX/MEM result, 01 WB data, 11 register value.
- wbData  input  WIDTH  value being written back in WB.
- writeRegIn  input  REG_ADDR  destination register.
- regWriteIn, memReadIn, memWriteIn, memToRegIn  input  1 each  downstream control bits.
- aluResultOut  output  WIDTH  registered ALU result.
- writeDataOut  output  WIDTH  registered forwarded B, used as store data.
- writeRegOut  output  REG_ADDR  registered destination register.
- regWriteOut, memReadOut, memWriteOut, memToRegOut  output  1 each  registered control bits.
- zeroOut  output  1  registered flag: ALU result equals 0.
- validOut  output  1  registered valid.

## Operation
- Operand A = mux(forwardA): readData1 / aluResultOut (current registered value) / wbData.
- Forwarded B = same mux on readData2 with forwardB. ALU operand B = aluSrc ? immediate : forwarded B. writeDataOut always captures forwarded B, never the immediate.
- ALU, combinational:
  - AND and OR are bitwise.
  - ADD and SUB wrap modulo 2^WIDTH. No overflow trap and no overflow output.
  - SLT gives 1 when A < B as signed two's-complement, else 0. Overflow must not corrupt the comparison: 0x80000000 < 0x7FFFFFFF gives 1.
  - Reserved codes (100, 101, 110) give result 0.
- zero = (ALU result == 0). It is computed for every code, including reserved codes (which give zero = 1).
- Control gating: when inValid = 0, regWrite, memRead, memWrite, memToReg and valid load as 0. Data fields still load.

## Timing
- Latency: 1 cycle. Inputs sampled at the rising edge appear on outputs immediately after that edge.
- Update priority at each edge is rst > flush > stall > normal load.
- rst = 1: every output is cleared to 0, including aluResultOut, writeDataOut, writeRegOut, all control bits, zeroOut and validOut.
- flush = 1: same clearing as reset. This applies even if stall = 1 in the same cycle.
- stall = 1 (flush = 0): every output holds its value.
  - While stalled, forward select 10 keeps returning the held aluResultOut.
- Normal load: all fields are captured together. There is no partial update.
- Forward select 10 in the cycle after rst or flush returns 0.
- No internal state exists beyond the EX/MEM register, so rst in mid-stream drops the in-flight instruction.

## Test plan
- Reset: hold rst for 2 cycles with arbitrary inputs -> every output is 0. Release rst with a valid ADD 3+4 -> aluResultOut = 7, validOut = 1, zeroOut = 0.
- Back-to-back forwarding:
  - Cycle 1: ADD 5+6 -> aluResultOut = 11.
  - Cycle 2: SUB with forwardA = 10, readData2 = 11 -> aluResultOut = 0, zeroOut = 1.
  - Repeat with forwardB = 01, wbData = 9 and A = 9 -> result 0.
- SLT signed: A = 0xFFFFFFFF, B = 1 -> 1. A = 0x80000000, B = 0x7FFFFFFF -> 1. A = 0x7FFFFFFF, B = 0x80000000 -> 0. Reserved code 101 -> result 0, zeroOut = 1.
- Store path: aluSrc = 1, immediate = 8, readData1 = 0x100, forwardB = 01, wbData = 0xABCD, memWriteIn = 1 -> aluResultOut = 0x108, writeDataOut = 0xABCD, memWriteOut = 1.
- Stall and flush:
  - Load OR 0xF0|0x0F -> 0xFF.
  - Assert stall for 3 cycles while changing inputs -> all outputs hold at 0xFF.
  - Assert stall and flush together -> all outputs become 0.
- Bubble: inValid = 0 with regWriteIn = 1 and memReadIn = 1 -> regWriteOut = 0, memReadOut = 0, validOut = 0, while aluResultOut still shows the computed value.
